// File: rtl/eth_rx_pkg.sv
// Shared constants and FSM encoding for the Ethernet receive path.
package eth_rx_pkg;
   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rxState_t;
endpackage

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 (reflected) next-state for one data byte.
module crc32_d8
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);
   logic [31:0] c;

   always_comb begin
      c = crc_in;
      // LSB-first: data bit 0 enters the register first
      for (int unsigned i = 0; i < 8; i++) begin
         c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY_REFL : '0);
      end
      crc_out = c;
   end
endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, forwards DA..FCS with Sop/Eop,
// and reports CRC, length and PHY error status on the Eop beat.
module gmii_rx_framer
   import eth_rx_pkg::*;
#(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518,
   parameter int unsigned MIN_PRE = 1
) (
   input  logic       RxClk,
   input  logic       rst,
   input  logic       ClkEN,
   input  logic [7:0] RxD,
   input  logic       RxDV,
   input  logic       RxER,
   output logic [7:0] Data,
   output logic       Valid,
   output logic       Sop,
   output logic       Eop,
   output logic       CrcErr,
   output logic       LenErr,
   output logic       PhyErr,
   output logic       FrameGood,
   output logic       FrameBad,
   output logic       PreErr
);
   rxState_t    state;
   logic [3:0]  preCnt;
   logic [31:0] crc;
   logic [31:0] crcNext;
   logic [15:0] len;
   logic        phySticky;
   logic [7:0]  holdByte;
   logic        holdValid;
   logic        holdFirst;

   logic        preOk;
   logic        crcBad;
   logic        lenBad;

   crc32_d8 u_crc (
      .crc_in  (crc),
      .d       (RxD),
      .crc_out (crcNext)
   );

   assign preOk  = 32'(preCnt) >= MIN_PRE;
   assign crcBad = crc != CRC_RESIDUE;
   assign lenBad = (32'(len) < MIN_LEN) || (32'(len) > MAX_LEN);

   always_ff @(posedge RxClk) begin
      if (rst) begin
         state     <= IDLE;
         preCnt    <= '0;
         crc       <= CRC_INIT;
         len       <= '0;
         phySticky <= 1'b0;
         holdByte  <= '0;
         holdValid <= 1'b0;
         holdFirst <= 1'b0;
         Data      <= '0;
         Valid     <= 1'b0;
         Sop       <= 1'b0;
         Eop       <= 1'b0;
         CrcErr    <= 1'b0;
         LenErr    <= 1'b0;
         PhyErr    <= 1'b0;
         FrameGood <= 1'b0;
         FrameBad  <= 1'b0;
         PreErr    <= 1'b0;
      end else begin
         // Pulse outputs default low so they last one RxClk even with sparse ClkEN
         Valid     <= 1'b0;
         Sop       <= 1'b0;
         Eop       <= 1'b0;
         CrcErr    <= 1'b0;
         LenErr    <= 1'b0;
         PhyErr    <= 1'b0;
         FrameGood <= 1'b0;
         FrameBad  <= 1'b0;
         PreErr    <= 1'b0;
         if (ClkEN) begin
            case (state)
               IDLE: begin
                  if (RxDV) begin
                     if (RxD == PREAMBLE_BYTE) begin
                        state  <= PRE;
                        preCnt <= 4'd1;
                     end else if (RxD == SFD_BYTE && MIN_PRE == 0) begin
                        state     <= DATA;
                        crc       <= CRC_INIT;
                        len       <= '0;
                        phySticky <= 1'b0;
                        holdValid <= 1'b0;
                     end else begin
                        PreErr <= 1'b1;
                        state  <= DROP;
                     end
                  end
               end
               PRE: begin
                  if (!RxDV) begin
                     state <= IDLE;
                  end else if (RxD == PREAMBLE_BYTE) begin
                     if (preCnt != 4'hF) preCnt <= preCnt + 4'd1;
                  end else if (RxD == SFD_BYTE && preOk) begin
                     state     <= DATA;
                     crc       <= CRC_INIT;
                     len       <= '0;
                     phySticky <= 1'b0;
                     holdValid <= 1'b0;
                  end else begin
                     PreErr <= 1'b1;
                     state  <= DROP;
                  end
               end
               DATA: begin
                  if (RxDV) begin
                     crc       <= crcNext;
                     if (len != '1) len <= len + 16'd1;
                     phySticky <= phySticky | RxER;
                     if (holdValid) begin
                        Data  <= holdByte;
                        Valid <= 1'b1;
                        Sop   <= holdFirst;
                     end
                     holdByte  <= RxD;
                     holdFirst <= ~holdValid;
                     holdValid <= 1'b1;
                  end else begin
                     if (holdValid) begin
                        Data      <= holdByte;
                        Valid     <= 1'b1;
                        Sop       <= holdFirst;
                        Eop       <= 1'b1;
                        CrcErr    <= crcBad;
                        LenErr    <= lenBad;
                        PhyErr    <= phySticky;
                        FrameGood <= ~(crcBad | lenBad | phySticky);
                        FrameBad  <= crcBad | lenBad | phySticky;
                     end
                     holdValid <= 1'b0;
                     state     <= IDLE;
                  end
               end
               DROP: begin
                  if (!RxDV) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed, table-driven bench for gmii_rx_framer with hand-built frames and FCS.
module tb_gmii_rx_framer;
   logic       RxClk = 1'b0;
   logic       rst;
   logic       ClkEN;
   logic [7:0] RxD;
   logic       RxDV;
   logic       RxER;
   logic [7:0] Data;
   logic       Valid, Sop, Eop, CrcErr, LenErr, PhyErr, FrameGood, FrameBad, PreErr;

   always #5 RxClk = ~RxClk;

   gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .MIN_PRE(1)) dut (
      .RxClk     (RxClk),
      .rst       (rst),
      .ClkEN     (ClkEN),
      .RxD       (RxD),
      .RxDV      (RxDV),
      .RxER      (RxER),
      .Data      (Data),
      .Valid     (Valid),
      .Sop       (Sop),
      .Eop       (Eop),
      .CrcErr    (CrcErr),
      .LenErr    (LenErr),
      .PhyErr    (PhyErr),
      .FrameGood (FrameGood),
      .FrameBad  (FrameBad),
      .PreErr    (PreErr)
   );

   int passCnt  = 0;
   int totalCnt = 0;

   task automatic check(input string name, input int act, input int exp);
      totalCnt++;
      if (act == exp) passCnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- output monitor ----------------
   int cyc = 0;
   always @(posedge RxClk) cyc++;

   logic [7:0] rxBuf [0:8191];
   int validCnt = 0, sopCnt = 0, eopCnt = 0, sopIdx = -1, eopIdx = -1;
   int goodCnt = 0, badCnt = 0, preErrCnt = 0, gapErr = 0, strayCnt = 0;
   int lastValidCyc = 0, lastCrc = 0, lastLen = 0, lastPhy = 0;
   int expGap = 1;

   always @(negedge RxClk) begin
      if (Valid) begin
         rxBuf[validCnt % 8192] = Data;
         if (Sop) begin
            sopCnt++;
            sopIdx = validCnt;
         end else if (cyc - lastValidCyc != expGap) begin
            gapErr++;
         end
         lastValidCyc = cyc;
         if (Eop) begin
            eopCnt++;
            eopIdx  = validCnt;
            lastCrc = int'(CrcErr);
            lastLen = int'(LenErr);
            lastPhy = int'(PhyErr);
         end
         validCnt++;
      end else if (Sop || Eop) begin
         strayCnt++;
      end
      if ((FrameGood || FrameBad) && !Eop) strayCnt++;
      if (FrameGood) goodCnt++;
      if (FrameBad)  badCnt++;
      if (PreErr)    preErrCnt++;
   end

   // ---------------- frame construction ----------------
   logic [7:0] txBuf [0:2047];
   int txLen = 0;

   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int j = 0; j < 8; j++) begin
         if (r[0] ^ b[j]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic buildFrame(input int len, input bit badFcs);
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
         b = 8'(i * 13 + len * 7 + 5);
         if (b == 8'h55 || b == 8'hD5) b = 8'h00;
         txBuf[i] = b;
         c = crcByte(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) txBuf[len - 4 + k] = c[8*k +: 8];
      if (badFcs) txBuf[len - 4][0] = ~txBuf[len - 4][0];
      txLen = len;
   endtask

   task automatic beat(input logic [7:0] d, input logic dv, input logic er, input int div);
      RxD = d; RxDV = dv; RxER = er; ClkEN = 1'b1;
      @(posedge RxClk); #1;
      ClkEN = 1'b0;
      for (int i = 1; i < div; i++) begin
         @(posedge RxClk); #1;
      end
   endtask

   task automatic sendFrame(input int div, input int erIdx, input int rstAt);
      for (int i = 0; i < 7; i++) beat(8'h55, 1'b1, 1'b0, div);
      beat(8'hD5, 1'b1, 1'b0, div);
      for (int i = 0; i < txLen; i++) begin
         if (i == rstAt) begin
            rst = 1'b1;
            @(posedge RxClk); #1;
            rst = 1'b0;
         end
         beat(txBuf[i], 1'b1, logic'(i == erIdx), div);
      end
      for (int i = 0; i < 3; i++) beat(8'h00, 1'b0, 1'b0, div);
   endtask

   // ---------------- table-driven frames ----------------
   typedef struct {
      int len;
      bit badFcs;
      int erIdx;
      int div;
      bit expCrc;
      bit expLen;
      bit expPhy;
   } vec_t;

   vec_t vecs [0:6];

   task automatic applyVector(input vec_t v, input string tag);
      int b0, s0, e0, g0, bd0, p0, gp0, mism;
      bit expGood;
      b0 = validCnt; s0 = sopCnt; e0 = eopCnt; g0 = goodCnt; bd0 = badCnt;
      p0 = preErrCnt; gp0 = gapErr;
      expGap = v.div;
      expGood = !(v.expCrc || v.expLen || v.expPhy);
      buildFrame(v.len, v.badFcs);
      sendFrame(v.div, v.erIdx, -1);
      mism = 0;
      for (int i = 0; i < txLen; i++)
         if (rxBuf[(b0 + i) % 8192] !== txBuf[i]) mism++;
      check({tag, " byteCount"}, validCnt - b0, v.len);
      check({tag, " dataMismatch"}, mism, 0);
      check({tag, " sopCount"}, sopCnt - s0, 1);
      check({tag, " sopIndex"}, sopIdx, b0);
      check({tag, " eopCount"}, eopCnt - e0, 1);
      check({tag, " eopIndex"}, eopIdx, b0 + v.len - 1);
      check({tag, " CrcErr"}, lastCrc, int'(v.expCrc));
      check({tag, " LenErr"}, lastLen, int'(v.expLen));
      check({tag, " PhyErr"}, lastPhy, int'(v.expPhy));
      check({tag, " FrameGood"}, goodCnt - g0, int'(expGood));
      check({tag, " FrameBad"}, badCnt - bd0, int'(!expGood));
      check({tag, " validSpacing"}, gapErr - gp0, 0);
      check({tag, " PreErr"}, preErrCnt - p0, 0);
   endtask

   int b0, p0, e0;

   initial begin
      vecs[0] = '{64,   1'b0, -1, 1,  1'b0, 1'b0, 1'b0};
      vecs[1] = '{64,   1'b1, -1, 1,  1'b1, 1'b0, 1'b0};
      vecs[2] = '{60,   1'b0, -1, 1,  1'b0, 1'b1, 1'b0};
      vecs[3] = '{1519, 1'b0, -1, 1,  1'b0, 1'b1, 1'b0};
      vecs[4] = '{1518, 1'b0, -1, 1,  1'b0, 1'b0, 1'b0};
      vecs[5] = '{100,  1'b0, 20, 1,  1'b0, 1'b0, 1'b1};
      vecs[6] = '{64,   1'b0, -1, 10, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; ClkEN = 1'b0; RxD = 8'h00; RxDV = 1'b0; RxER = 1'b0;
      repeat (3) @(posedge RxClk);
      #1;
      check("resetOutputs",
            int'({Data, Valid, Sop, Eop, CrcErr, LenErr, PhyErr, FrameGood, FrameBad, PreErr}), 0);
      rst = 1'b0;
      repeat (2) @(posedge RxClk);
      #1;

      for (int i = 0; i < 7; i++) applyVector(vecs[i], $sformatf("vec%0d", i));

      // RxER without RxDV in IDLE must be ignored
      b0 = validCnt; p0 = preErrCnt;
      for (int i = 0; i < 5; i++) beat(8'hA5, 1'b0, 1'b1, 1);
      beat(8'h00, 1'b0, 1'b0, 1);
      check("falseCarrier valid", validCnt - b0, 0);
      check("falseCarrier PreErr", preErrCnt - p0, 0);

      // Preamble violation 55 55 A3 ... then a good frame
      b0 = validCnt; p0 = preErrCnt;
      beat(8'h55, 1'b1, 1'b0, 1);
      beat(8'h55, 1'b1, 1'b0, 1);
      beat(8'hA3, 1'b1, 1'b0, 1);
      beat(8'hD5, 1'b1, 1'b0, 1);
      beat(8'h11, 1'b1, 1'b0, 1);
      beat(8'h22, 1'b1, 1'b0, 1);
      for (int i = 0; i < 2; i++) beat(8'h00, 1'b0, 1'b0, 1);
      check("badPreamble valid", validCnt - b0, 0);
      check("badPreamble PreErr", preErrCnt - p0, 1);
      applyVector(vecs[0], "afterBadPre");

      // Bare SFD with MIN_PRE=1
      b0 = validCnt; p0 = preErrCnt;
      beat(8'hD5, 1'b1, 1'b0, 1);
      for (int i = 0; i < 6; i++) beat(8'(i + 1), 1'b1, 1'b0, 1);
      for (int i = 0; i < 2; i++) beat(8'h00, 1'b0, 1'b0, 1);
      check("bareSfd valid", validCnt - b0, 0);
      check("bareSfd PreErr", preErrCnt - p0, 1);
      applyVector(vecs[0], "afterBareSfd");

      // Reset at byte 30 of a slow frame, RxDV kept high afterwards
      expGap = 10;
      buildFrame(64, 1'b0);
      sendFrame(10, -1, 30);
      check("rstMidFrame outputs", validCnt - b0 >= 0 ? 0 : 1, 0);
      applyVector(vecs[6], "afterReset");

      check("strayFraming", strayCnt, 0);
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

   // Post-reset activity for the mid-frame reset case is tracked by snapshots
   // taken on the rst pulse itself.
   int rstValid0 = 0, rstEop0 = 0, rstPre0 = 0;
   bit rstSeen = 1'b0;
   always @(negedge RxClk) begin
      if (rst && cyc > 10) begin
         rstValid0 = validCnt;
         rstEop0   = eopCnt;
         rstPre0   = preErrCnt;
         rstSeen   = 1'b1;
      end
   end

   final begin
   end

   initial begin
      wait (rstSeen);
      // The interrupted frame ends after 34 more beats plus 3 idle beats at 10 clocks each
      repeat (400) @(posedge RxClk);
      #2;
      check("rstMidFrame noValid", validCnt - rstValid0, 0);
      check("rstMidFrame noEop", eopCnt - rstEop0, 0);
      check("rstMidFrame PreErr", preErrCnt - rstPre0, 1);
   end
endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
- Sits directly downstream of the RGMII-to-GMII receive converter, in the RxClk domain.
- Consumes the GMII byte stream (RxD/RxDV/RxER) and locates preamble/SFD, then strips them.
- Delivers frame bytes (DA through FCS) with Sop/Eop framing to the MAC receive path.
- Checks CRC-32 and frame length, and reports per-frame status on the Eop beat.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, DA..FCS inclusive.
- MAX_LEN, 1518: maximum legal frame length in bytes, DA..FCS inclusive.
- MIN_PRE, 1: minimum 0x55 preamble bytes required before SFD (0 accepts a bare SFD).

Ports:
- RxClk in 1: receive clock, the only clock.
- rst in 1: synchronous, active-high reset.
- ClkEN in 1: byte qualifier. 1 every cycle at 1000 Mb/s, 1 cycle in 10 at 100 Mb/s, 1 in 100 at 10 Mb/s.
- RxD in 8: GMII receive data.
- RxDV in 1: GMII receive data valid.
- RxER in 1: GMII receive error.
- Data out 8: frame byte.
- Valid out 1: Data/Sop/Eop qualifier; one-clock pulse per byte.
- Sop out 1: first frame byte (DA[0]).
- Eop out 1: last frame byte (FCS[3]).
- CrcErr out 1: FCS mismatch; meaningful only with Eop.
- LenErr out 1: length < MIN_LEN or > MAX_LEN; meaningful only with Eop.
- PhyErr out 1: RxER seen during the frame; meaningful only with Eop.
- FrameGood out 1: one-clock pulse with Eop when no error flag is set.
- FrameBad out 1: one-clock pulse with Eop when any error flag is set.
- PreErr out 1: one-clock pulse when a preamble/SFD violation forces a drop.

Behaviour:
- All inputs are sampled only on cycles with ClkEN=1 ("beats"). When ClkEN=0, state, CRC and counters hold.
- All outputs are registered. On rst every output is 0, the FSM is in IDLE, the CRC register is 32'hFFFFFFFF, and the length counter and sticky flags are 0.
- Valid, Sop, Eop, FrameGood, FrameBad and PreErr are single-RxClk pulses, even when ClkEN is sparse.
- FSM states:
  - IDLE:
    - RxDV=0: stay.
    - RxDV=1 and RxD=0x55: go to PRE with pre_cnt=1.
    - RxDV=1 and RxD=0xD5 with MIN_PRE=0: go to DATA.
    - Any other RxDV=1 beat: pulse PreErr and go to DROP.
    - RxER with RxDV=0 (false carrier / carrier extend) is ignored.
  - PRE:
    - 0x55: increment pre_cnt (saturates at 15).
    - 0xD5 with pre_cnt>=MIN_PRE: go to DATA, clear CRC/len/flags.
    - 0xD5 with pre_cnt<MIN_PRE, or any other byte: pulse PreErr and go to DROP.
    - RxDV=0: go to IDLE silently.
  - DATA:
    - Each RxDV=1 beat: update CRC with RxD, len++ (16-bit, saturating at 16'hFFFF), PhyErr_sticky |= RxER.
    - The byte goes into a one-byte hold register. The previously held byte (if any) is emitted with Valid=1, and Sop=1 if it was the first byte.
    - RxDV=0 beat: emit the held byte with Valid=1 and Eop=1, plus the status flags, then go to IDLE.
    - If zero bytes followed the SFD, emit nothing and go to IDLE.
    - A one-byte frame asserts Sop and Eop together.
  - DROP:
    - Ignore all data until an RxDV=0 beat, then go to IDLE. No output is produced.
- Latency: byte k appears on Data one RxClk after the beat presenting byte k+1. The last byte appears one RxClk after the RxDV=0 beat.
- CRC: IEEE 802.3 CRC-32, reflected/LSB-first, init 32'hFFFFFFFF, computed over DA..FCS. CrcErr=1 unless the final register equals 32'hDEBB20E3.
- Length: LenErr=1 if len<MIN_LEN or len>MAX_LEN. The frame is still forwarded in full; giants are not truncated.
- rst mid-frame: outputs are cleared the next clock and the FSM goes to IDLE. A still-asserted RxDV with non-0x55 data then goes to DROP, so a partial frame is never emitted.
- Back-to-back frames: an IPG of one RxDV=0 beat suffices. A new preamble may begin on the beat after the Eop-triggering beat.

Decomposition:
- Shared package (eth_rx_pkg):
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
  - CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3, CRC_POLY_REFL=32'hEDB88320.
  - FSM state enum {IDLE, PRE, DATA, DROP}.
- One sub-module: crc32_d8. Combinational next-CRC for 8 data bits: crc_in[31:0] and d[7:0] to crc_out[31:0]. It is reused later by the TX FCS inserter.

Test Plan:
- Good frame: 7x55, D5, 64-byte frame with correct FCS, ClkEN=1 → 64 Valid pulses, Sop on byte 0, Eop on byte 63, CrcErr=LenErr=PhyErr=0, FrameGood=1.
- Bad FCS: same frame with FCS[0] bit 0 flipped → CrcErr=1, FrameBad=1, all 64 bytes still forwarded.
- Runt/giant:
  - Valid-CRC 60-byte frame → LenErr=1.
  - Valid-CRC 1519-byte frame → LenErr=1.
  - 1518-byte frame → LenErr=0.
- PHY error: RxER=1 on byte 20 of a good 100-byte frame → PhyErr=1, FrameBad=1. RxER with RxDV=0 in IDLE → no output.
- Preamble violation: 55 55 A3 … → PreErr pulse, no Valid until the next frame. Bare D5 with MIN_PRE=1 → PreErr. The next good frame is received normally.
- ClkEN=1-in-10 with a 64-byte good frame → identical byte sequence, Valid pulses spaced 10 clocks apart. rst asserted at byte 30, then released with RxDV still high → no Eop, no further output until the next frame, which passes with FrameGood=1.
